// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO.
// Holds the default address width and the Gray/binary conversion helpers
// used by both pointer domains. The helpers work on a fixed maximum width.
// Callers zero-extend narrower pointers on the way in and cast the result
// back on the way out.
// Leading zeros do not change either conversion, so one pair of functions
// covers every pointer width up to GRAY_MAX_W.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int GRAY_MAX_W         = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Write-domain control for the asynchronous FIFO.
// This block keeps the binary write pointer and its Gray copy; the Gray copy
// goes to the write-to-read synchronizer.
// Full, almost-full and fill level are registered flags. They are derived
// from the read pointer after it has been synchronized into clk. Overflow is
// a sticky flag.
//
// Ports
//   clk          write-domain clock
//   reset        asynchronous, active-low
//   wr_en        producer write request
//   rptr_sync    Gray read pointer, already synchronized to clk
//   ovf_clr      clears the sticky overflow flag
//   wr_accept    memory write strobe (wr_en & ~full, held low in reset)
//   wr_addr      memory write address
//   wptr_gray    registered Gray write pointer for the synchronizer
//   full         registered full flag
//   almost_full  registered, level >= AFULL_THRESH
//   wr_level     registered occupancy seen from the write side
//   overflow     sticky; a write was attempted while full
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  input  logic                  ovf_clr,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int A  = ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wgray_q,  wgray_d;
  logic          full_q,   full_d;
  logic          afull_q,  afull_d;
  logic [PW-1:0] level_q,  level_d;
  logic          ovf_q,    ovf_d;

  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rgray_full;

  // Without the reset term, wr_en would reach the memory strobe while
  // reset is held, because full reads 0 in reset.
  assign wr_accept = wr_en & ~full_q & reset;

  assign rbin_s = PW'(gray2bin(GRAY_MAX_W'(rptr_sync)));

  // The write pointer is exactly one lap ahead of the read pointer in this
  // Gray pattern: the top two bits are inverted and the rest are equal.
  assign rgray_full = {~rptr_sync[A:A-1], rptr_sync[A-2:0]};

  always_comb begin
    wbin_d  = wbin_q + {{A{1'b0}}, wr_accept};
    wgray_d = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
    level_d = wbin_d - rbin_s;
    full_d  = (wgray_d == rgray_full);
    afull_d = (level_d >= AFULL_LVL);
    // A write attempt while full takes priority over a clear on the same edge.
    ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = wbin_q[A-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] rptr_sync;
  logic       ovf_clr;
  logic       wr_accept;
  logic [2:0] wr_addr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rptr_sync  (rptr_sync),
    .ovf_clr    (ovf_clr),
    .wr_accept  (wr_accept),
    .wr_addr    (wr_addr),
    .wptr_gray  (wptr_gray),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .overflow   (overflow)
  );

  typedef struct {
    string      name;
    logic       acc;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       f;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic acc_snap = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // wr_accept is combinational, so it is captured before the edge it strobes.
  always @(negedge clk) begin
    #2 acc_snap = wr_accept;
  end

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".wr_accept"},   32'(acc_snap),    32'(e.acc));
        chk({e.name, ".wr_addr"},     32'(wr_addr),     32'(e.addr));
        chk({e.name, ".wptr_gray"},   32'(wptr_gray),   32'(e.gray));
        chk({e.name, ".full"},        32'(full),        32'(e.f));
        chk({e.name, ".almost_full"}, 32'(almost_full), 32'(e.af));
        chk({e.name, ".wr_level"},    32'(wr_level),    32'(e.lvl));
        chk({e.name, ".overflow"},    32'(overflow),    32'(e.ovf));
      end
    end
  end

  // Drive one cycle of inputs at a negedge, queue the state expected after the
  // following posedge, then move on to the next negedge.
  task automatic step(input string name, input logic we, input logic [3:0] rp, input logic clr,
                      input logic acc, input logic [2:0] addr, input logic [3:0] gray,
                      input logic f, input logic af, input logic [3:0] lvl, input logic ovf);
    exp_t e;
    wr_en     = we;
    rptr_sync = rp;
    ovf_clr   = clr;
    e.name = name; e.acc = acc; e.addr = addr; e.gray = gray;
    e.f = f; e.af = af; e.lvl = lvl; e.ovf = ovf;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".wr_accept"},   32'(wr_accept),   32'd0);
    chk({name, ".wr_addr"},     32'(wr_addr),     32'd0);
    chk({name, ".wptr_gray"},   32'(wptr_gray),   32'd0);
    chk({name, ".full"},        32'(full),        32'd0);
    chk({name, ".almost_full"}, 32'(almost_full), 32'd0);
    chk({name, ".wr_level"},    32'(wr_level),    32'd0);
    chk({name, ".overflow"},    32'(overflow),    32'd0);
  endtask

  initial begin
    int guard;
    reset = 1'b0; wr_en = 1'b1; rptr_sync = 4'h0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_hold");
    reset = 1'b1;

    //   name     we rp   clr acc addr gray  f  af lvl  ovf
    step("w1", 1, 4'h0, 0, 1, 3'd1, 4'h1, 0, 0, 4'd1, 0);
    step("w2", 1, 4'h0, 0, 1, 3'd2, 4'h3, 0, 0, 4'd2, 0);
    step("w3", 1, 4'h0, 0, 1, 3'd3, 4'h2, 0, 0, 4'd3, 0);
    step("w4", 1, 4'h0, 0, 1, 3'd4, 4'h6, 0, 0, 4'd4, 0);
    step("w5", 1, 4'h0, 0, 1, 3'd5, 4'h7, 0, 0, 4'd5, 0);
    step("w6", 1, 4'h0, 0, 1, 3'd6, 4'h5, 0, 1, 4'd6, 0);
    step("w7", 1, 4'h0, 0, 1, 3'd7, 4'h4, 0, 1, 4'd7, 0);
    step("w8", 1, 4'h0, 0, 1, 3'd0, 4'hC, 1, 1, 4'd8, 0);

    step("ovf_set",   1, 4'h0, 0, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    step("ovf_win",   1, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    step("ovf_clr",   0, 4'h0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);

    step("drain1",    0, 4'h1, 0, 0, 3'd0, 4'hC, 0, 1, 4'd7, 0);
    step("drain2",    0, 4'h3, 0, 0, 3'd0, 4'hC, 0, 1, 4'd6, 0);

    step("w9",  1, 4'hC, 0, 1, 3'd1, 4'hD, 0, 0, 4'd1, 0);
    step("w10", 1, 4'hC, 0, 1, 3'd2, 4'hF, 0, 0, 4'd2, 0);
    step("w11", 1, 4'hC, 0, 1, 3'd3, 4'hE, 0, 0, 4'd3, 0);
    step("w12", 1, 4'hC, 0, 1, 3'd4, 4'hA, 0, 0, 4'd4, 0);
    step("w13", 1, 4'hC, 0, 1, 3'd5, 4'hB, 0, 0, 4'd5, 0);
    step("w14", 1, 4'hC, 0, 1, 3'd6, 4'h9, 0, 1, 4'd6, 0);
    step("w15", 1, 4'hC, 0, 1, 3'd7, 4'h8, 0, 1, 4'd7, 0);
    step("w16", 1, 4'hC, 0, 1, 3'd0, 4'h0, 1, 1, 4'd8, 0);
    step("wrap_rel",  0, 4'hD, 0, 0, 3'd0, 4'h0, 0, 1, 4'd7, 0);
    step("wr_and_rd", 1, 4'hF, 0, 1, 3'd1, 4'h1, 0, 1, 4'd7, 0);
    step("lvl5",      0, 4'hA, 0, 0, 3'd1, 4'h1, 0, 0, 4'd5, 0);

    // Asynchronous reset mid-operation: outputs clear before any clock edge.
    #2 reset = 1'b0;
    #1 chk_zero("reset_async");
    rptr_sync = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    step("post_rst_w1", 1, 4'h0, 0, 1, 3'd1, 4'h1, 0, 0, 4'd1, 0);
    wr_en = 1'b0;

    guard = 0;
    while (q.size() != 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
